stream_reduce: RTL and testbench

STREAM_REDUCE -- requirements
Module: stream_reduce

---
 rtl/stream_reduce_pkg.sv | 18 +
 rtl/reduce_alu.sv | 27 ++
 rtl/stream_reduce.sv | 120 ++++++++++++
 tb/tb_stream_reduce.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_reduce_pkg.sv
// Shared types for the stream_reduce block: reduction operator encoding
// and FSM state encoding.
package stream_reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/reduce_alu.sv
// Combinational reduction step: folds one input word into the accumulator.
// NAND folds as AND; the final inversion is applied at the output of the
// top level, so the running value stays a plain AND reduction.
module reduce_alu
  import stream_reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] in_data,
  input  op_t              op,
  output logic [WIDTH-1:0] next_acc
);

  // One bitwise fold selected by the latched operator
  always_comb begin
    next_acc = acc & in_data;
    case (op)
      OP_AND:  next_acc = acc & in_data;
      OP_OR:   next_acc = acc | in_data;
      OP_XOR:  next_acc = acc ^ in_data;
      OP_NAND: next_acc = acc & in_data;
      default: next_acc = acc & in_data;
    endcase
  end

endmodule

// File: rtl/stream_reduce.sv
// stream_reduce: reduces a burst of words with AND/OR/XOR/NAND and presents
// the result with a valid/ready handshake, one cycle after the last beat.
// Optional feature: define STREAM_REDUCE_COUNT_EN to add out_count, the
// saturating number of beats in the burst.
module stream_reduce
  import stream_reduce_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef STREAM_REDUCE_COUNT_EN
  ,
  output logic [$clog2(MAX_BEATS+1)-1:0] out_count
`endif
);

  if (WIDTH < 1 || WIDTH > 64 || MAX_BEATS < 1 || MAX_BEATS > 65535) begin : g_param_check
    $error("stream_reduce: WIDTH must be 1..64 and MAX_BEATS 1..65535");
  end

  state_t           state_p0;
  state_t           state_nx;
  logic [WIDTH-1:0] acc_p0;
  op_t              op_p0;
  logic [WIDTH-1:0] next_acc;
  logic             accept;

  assign accept = in_valid & in_ready;

  reduce_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .acc     (acc_p0),
    .in_data (in_data),
    .op      (op_p0),
    .next_acc(next_acc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_nx;
    end
  end

  // Next state and handshake outputs; both handshakes are forced low in reset
  always_comb begin
    state_nx  = state_p0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_p0)
      IDLE, ACCUM: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          state_nx = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        out_valid = ~rst;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulator and operator latch: first beat loads, later beats fold
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0 <= '0;
      op_p0  <= OP_AND;
    end else if (accept) begin
      if (state_p0 == IDLE) begin
        acc_p0 <= in_data;
        op_p0  <= op_t'(op);
      end else begin
        acc_p0 <= next_acc;
      end
    end
  end

  // Result is driven only while holding so nothing partial leaks out
  assign out_data = (state_p0 == HOLD && !rst) ?
                    ((op_p0 == OP_NAND) ? ~acc_p0 : acc_p0) : '0;

`ifdef STREAM_REDUCE_COUNT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] cnt_p0;

  // Beat counter, restarted by the first beat and held at MAX_BEATS
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (accept) begin
      if (state_p0 == IDLE) begin
        cnt_p0 <= CNT_W'(1);
      end else if (cnt_p0 != CNT_W'(MAX_BEATS)) begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  assign out_count = cnt_p0;
`endif

endmodule

// File: tb/tb_stream_reduce.sv
// Self-checking bench for stream_reduce (WIDTH=8, MAX_BEATS=4).
// Expected results are queued when a burst's last beat is driven and
// compared when the DUT completes an output handshake.
module tb_stream_reduce;

  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   in_op;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
`ifdef STREAM_REDUCE_COUNT_EN
  logic [2:0]   out_count;
`endif

  stream_reduce #(
    .WIDTH    (W),
    .MAX_BEATS(MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (in_op),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef STREAM_REDUCE_COUNT_EN
    ,
    .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] bq[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference reduction over bq[0..n-1]
  function automatic logic [W-1:0] model(input logic [1:0] o, input int n);
    logic [W-1:0] a;
    a = bq[0];
    for (int i = 1; i < n; i++) begin
      case (o)
        2'b01:   a = a | bq[i];
        2'b10:   a = a ^ bq[i];
        default: a = a & bq[i];
      endcase
    end
    if (o == 2'b11) a = ~a;
    return a;
  endfunction

  // Drive one beat and hold it until accepted; call at a settled point
  task automatic beat(input logic [W-1:0] d, input logic last, input logic [1:0] o);
    int n;
    in_data  = d;
    in_last  = last;
    in_op    = o;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rdy_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic void push(input logic [W-1:0] d, input int n);
    exp_t e;
    e.data = d;
    e.cnt  = (n > MB) ? MB : n;
    sb.push_back(e);
  endfunction

  // Send the n words in bq as one burst and check the one-cycle latency
  task automatic burst(input logic [1:0] o, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) push(model(o, n), n);
      beat(bq[i], (i == n - 1), o);
    end
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(out_data), 64'(e.data));
`ifdef STREAM_REDUCE_COUNT_EN
        chk("count", 64'(out_count), 64'(e.cnt));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_op = 2'b00; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;

    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
`ifdef STREAM_REDUCE_COUNT_EN
    chk("rst_cnt", 64'(out_count), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(in_ready), 64'd1);
    chk("post_rst_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;

    // AND FF,0F,3C -> 0C
    bq = '{8'hFF, 8'h0F, 8'h3C};
    burst(2'b00, 3);
    @(posedge clk); #1;

    // XOR A5,5A,FF -> 00 ; NAND F0 -> 0F
    bq = '{8'hA5, 8'h5A, 8'hFF};
    burst(2'b10, 3);
    @(posedge clk); #1;
    bq = '{8'hF0};
    burst(2'b11, 1);
    @(posedge clk); #1;

    // OR 01,80 with downstream stalled for 5 cycles
    out_ready = 1'b0;
    bq = '{8'h01, 8'h80};
    burst(2'b01, 2);
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'h81);
      chk("hold_rdy", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_rdy", 64'(in_ready), 64'd1);
    chk("release_vld", 64'(out_valid), 64'd0);

    // AND burst, op switched to XOR on later beats, with idle gaps
    beat(8'hFF, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h00; in_op = 2'b10;
      @(negedge clk);
      chk("gap_rdy", 64'(in_ready), 64'd1);
    end
    @(posedge clk); #1;
    beat(8'h3C, 1'b0, 2'b10);
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    push(8'h24, 3);
    beat(8'h66, 1'b1, 2'b10);
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Reset mid-burst discards the partial result
    beat(8'hC0, 1'b0, 2'b01);
    beat(8'h0C, 1'b0, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", 64'(in_ready), 64'd0);
    chk("midrst_vld", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_vld", 64'(out_valid), 64'd0);
      chk("after_rst_rdy", 64'(in_ready), 64'd1);
    end
    @(posedge clk); #1;
    bq = '{8'h33};
    burst(2'b01, 1);
    @(posedge clk); #1;

    // Count saturation: 6-beat and 3-beat bursts
    bq = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF};
    burst(2'b00, 6);
    @(posedge clk); #1;
    bq = '{8'h11, 8'h22, 8'h44};
    burst(2'b01, 3);
    @(posedge clk); #1;

    // Random bursts
    for (int k = 0; k < 8; k++) begin
      int n;
      logic [1:0] o;
      n = $urandom_range(1, 6);
      o = 2'($urandom_range(0, 3));
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      burst(o, n);
      @(posedge clk); #1;
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
